// File: rtl/engine_pkg.sv
// Shared types and sizing helpers for the multi-channel convolution accumulator.
package engine_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Accumulator width that holds CHANNEL_NB * KERNEL_NB signed products without overflow.
    function automatic int acc_width(input int iw, input int ww, input int kn, input int cn);
        return iw + ww + $clog2(kn * cn) + 1;
    endfunction

endpackage

// File: rtl/engine_acc_window_mac.sv
// window_mac: combinational signed dot product of one kernel window, sign-extended to ACC_WIDTH.
module window_mac
    import engine_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int IMAGE_WIDTH  = 16,
    parameter int KERNEL_NB    = 9,
    parameter int ACC_WIDTH    = acc_width(IMAGE_WIDTH, WEIGHT_WIDTH, KERNEL_NB, 1)
)(
    input  logic [KERNEL_NB*WEIGHT_WIDTH-1:0] weights,
    input  logic [KERNEL_NB*IMAGE_WIDTH-1:0]  pixels,
    output logic [ACC_WIDTH-1:0]              dot
);

    logic signed [ACC_WIDTH-1:0] sum_s;
    logic signed [ACC_WIDTH-1:0] w_ext_s;
    logic signed [ACC_WIDTH-1:0] p_ext_s;

    // Sum of sign-extended products; truncation to ACC_WIDTH is exact by construction.
    always_comb begin
        sum_s   = {ACC_WIDTH{1'b0}};
        w_ext_s = {ACC_WIDTH{1'b0}};
        p_ext_s = {ACC_WIDTH{1'b0}};
        for (int k = 0; k < KERNEL_NB; k++) begin
            w_ext_s = ACC_WIDTH'($signed(weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            p_ext_s = ACC_WIDTH'($signed(pixels[k*IMAGE_WIDTH +: IMAGE_WIDTH]));
            sum_s   = sum_s + w_ext_s * p_ext_s;
        end
        dot = sum_s;
    end

endmodule

// File: rtl/engine_acc.sv
// engine_acc: multi-channel convolution engine accumulating CHANNEL_NB beats per result.
// Optional ENGINE_RELU_EN clamps negative lanes to zero when loading the result register.
module engine_acc
    import engine_pkg::*;
#(
    parameter  int WEIGHT_WIDTH  = 8,
    parameter  int IMAGE_WIDTH   = 16,
    parameter  int IMAGE_NB      = 8,
    parameter  int KERNEL_WIDTH  = 3,
    parameter  int KERNEL_HEIGHT = 3,
    parameter  int CHANNEL_NB    = 4,
    localparam int KERNEL_NB     = KERNEL_WIDTH * KERNEL_HEIGHT,
    localparam int WORD_WIDTH    = IMAGE_WIDTH * IMAGE_NB,
    localparam int ACC_WIDTH     = acc_width(IMAGE_WIDTH, WEIGHT_WIDTH, KERNEL_NB, CHANNEL_NB)
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WEIGHT_WIDTH-1:0]           weight,
    input  logic                              weight_valid,
    output logic                              weight_ready,
    input  logic                              reload,
    input  logic [KERNEL_HEIGHT*WORD_WIDTH-1:0] image,
    input  logic                              image_valid,
    output logic                              image_ready,
    output logic [ACC_WIDTH*IMAGE_NB-1:0]     result,
    output logic                              result_valid,
    input  logic                              result_ready
);

    localparam int C_W = (CHANNEL_NB > 1) ? $clog2(CHANNEL_NB) : 1;
    localparam int J_W = (KERNEL_NB > 1) ? $clog2(KERNEL_NB) : 1;
    localparam int L_W = ACC_WIDTH * IMAGE_NB;

    localparam logic [C_W-1:0] C_LAST = C_W'(CHANNEL_NB - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(KERNEL_NB - 1);

    state_t state_r;
    state_t state_next_s;

    logic [WEIGHT_WIDTH-1:0] weight_mem_r [CHANNEL_NB][KERNEL_NB];
    logic [C_W-1:0]          w_ch_r;
    logic [J_W-1:0]          w_idx_r;
    logic [C_W-1:0]          c_r;

    logic [L_W-1:0] s1_sum_r;
    logic           s1_valid_r;
    logic           s1_last_r;
    logic           s1_first_r;
    logic [L_W-1:0] acc_r;
    logic [L_W-1:0] result_r;
    logic           result_valid_r;

    logic                            stall_s;
    logic                            weight_fire_s;
    logic                            w_last_s;
    logic                            beat_take_s;
    logic [KERNEL_NB*WEIGHT_WIDTH-1:0] cur_w_s;
    logic [L_W-1:0]                  lane_sum_s;
    logic [L_W-1:0]                  acc_sum_s;
    logic [L_W-1:0]                  res_next_s;

    assign stall_s       = result_valid_r && !result_ready;
    assign weight_fire_s = weight_valid && weight_ready;
    assign w_last_s      = (w_ch_r == C_LAST) && (w_idx_r == J_LAST);
    // A beat arriving together with reload is handshaken but discarded.
    assign beat_take_s   = image_valid && image_ready && !reload;

    assign result       = result_r;
    assign result_valid = result_valid_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (weight_fire_s && w_last_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                if (reload) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN:   state_next_s = LOAD;
            default: state_next_s = LOAD;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        weight_ready = 1'b0;
        image_ready  = 1'b0;
        case (state_r)
            LOAD:    weight_ready = 1'b1;
            RUN:     image_ready  = !stall_s;
            DRAIN:   image_ready  = 1'b0;
            default: weight_ready = 1'b0;
        endcase
    end

    // Weight load address, walking channel-major through the store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ch_r  <= {C_W{1'b0}};
            w_idx_r <= {J_W{1'b0}};
        end else if (weight_fire_s) begin
            if (w_idx_r == J_LAST) begin
                w_idx_r <= {J_W{1'b0}};
                w_ch_r  <= w_last_s ? {C_W{1'b0}} : w_ch_r + C_W'(1);
            end else begin
                w_idx_r <= w_idx_r + J_W'(1);
            end
        end
    end

    // Weight store write port.
    always_ff @(posedge clk) begin
        if (weight_fire_s) begin
            weight_mem_r[w_ch_r][w_idx_r] <= weight;
        end
    end

    for (genvar j = 0; j < KERNEL_NB; j++) begin : g_wsel
        assign cur_w_s[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weight_mem_r[c_r][j];
    end

    for (genvar s = 0; s < IMAGE_NB; s++) begin : g_lane
        logic [KERNEL_NB*IMAGE_WIDTH-1:0] win_s;

        // Window columns wrap around the row.
        for (genvar kh = 0; kh < KERNEL_HEIGHT; kh++) begin : g_kh
            for (genvar kw = 0; kw < KERNEL_WIDTH; kw++) begin : g_kw
                assign win_s[(kh*KERNEL_WIDTH + kw)*IMAGE_WIDTH +: IMAGE_WIDTH] =
                    image[kh*WORD_WIDTH + ((s + kw) % IMAGE_NB)*IMAGE_WIDTH +: IMAGE_WIDTH];
            end
        end

        window_mac #(
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .IMAGE_WIDTH  (IMAGE_WIDTH),
            .KERNEL_NB    (KERNEL_NB),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_mac (
            .weights (cur_w_s),
            .pixels  (win_s),
            .dot     (lane_sum_s[s*ACC_WIDTH +: ACC_WIDTH])
        );

        assign acc_sum_s[s*ACC_WIDTH +: ACC_WIDTH] = s1_first_r
            ? s1_sum_r[s*ACC_WIDTH +: ACC_WIDTH]
            : acc_r[s*ACC_WIDTH +: ACC_WIDTH] + s1_sum_r[s*ACC_WIDTH +: ACC_WIDTH];

`ifdef ENGINE_RELU_EN
        assign res_next_s[s*ACC_WIDTH +: ACC_WIDTH] = acc_sum_s[s*ACC_WIDTH + ACC_WIDTH - 1]
            ? {ACC_WIDTH{1'b0}} : acc_sum_s[s*ACC_WIDTH +: ACC_WIDTH];
`else
        assign res_next_s[s*ACC_WIDTH +: ACC_WIDTH] = acc_sum_s[s*ACC_WIDTH +: ACC_WIDTH];
`endif
    end

    // S1, accumulator and result register; everything freezes while the result is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r            <= {C_W{1'b0}};
            s1_sum_r       <= {L_W{1'b0}};
            s1_valid_r     <= 1'b0;
            s1_last_r      <= 1'b0;
            s1_first_r     <= 1'b0;
            acc_r          <= {L_W{1'b0}};
            result_r       <= {L_W{1'b0}};
            result_valid_r <= 1'b0;
        end else if (state_r == DRAIN) begin
            // Discard any partial group; a finished result stays until popped.
            c_r        <= {C_W{1'b0}};
            s1_valid_r <= 1'b0;
            acc_r      <= {L_W{1'b0}};
            if (result_ready) begin
                result_valid_r <= 1'b0;
            end
        end else if (!stall_s) begin
            if (beat_take_s) begin
                s1_sum_r   <= lane_sum_s;
                s1_valid_r <= 1'b1;
                s1_last_r  <= (c_r == C_LAST);
                s1_first_r <= (c_r == {C_W{1'b0}});
                c_r        <= (c_r == C_LAST) ? {C_W{1'b0}} : c_r + C_W'(1);
            end else begin
                s1_valid_r <= 1'b0;
            end
            if (s1_valid_r && s1_last_r) begin
                result_r       <= res_next_s;
                result_valid_r <= 1'b1;
                acc_r          <= {L_W{1'b0}};
            end else begin
                if (s1_valid_r) begin
                    acc_r <= acc_sum_s;
                end
                if (result_valid_r && result_ready) begin
                    result_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/engine_acc.md
# engine_acc

Multi-channel successor to the single-channel convolution engine. It stores a full CHANNEL_NB × KERNEL_HEIGHT × KERNEL_WIDTH signed weight set, loaded over a valid/ready handshake. It accepts one channel's KERNEL_HEIGHT image rows per beat and accumulates the per-lane window dot products over CHANNEL_NB consecutive beats. It emits one IMAGE_NB-lane result word per channel group over a valid/ready handshake, sitting between the line-buffer front end and the output writer.

## Interface
- WEIGHT_WIDTH, 8: signed weight width
- IMAGE_WIDTH, 16: signed pixel width
- IMAGE_NB, 8: pixels per row word, and output lanes
- KERNEL_WIDTH, 3: kernel columns
- KERNEL_HEIGHT, 3: kernel rows
- CHANNEL_NB, 4: input channels accumulated per result (≥1)
- localparam KERNEL_NB = KERNEL_WIDTH*KERNEL_HEIGHT
- localparam WORD_WIDTH = IMAGE_WIDTH*IMAGE_NB
- localparam ACC_WIDTH = IMAGE_WIDTH+WEIGHT_WIDTH+$clog2(KERNEL_NB*CHANNEL_NB)+1

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- weight  in  WEIGHT_WIDTH  signed weight
- weight_valid  in  1
- weight_ready  out  1
- reload  in  1  single-cycle request to replace the weight set
- image  in  KERNEL_HEIGHT*WORD_WIDTH  row h at [h*WORD_WIDTH +: WORD_WIDTH]; pixel i at [i*IMAGE_WIDTH +: IMAGE_WIDTH] within its row
- image_valid  in  1
- image_ready  out  1
- result  out  ACC_WIDTH*IMAGE_NB  signed; lane s at [s*ACC_WIDTH +: ACC_WIDTH]
- result_valid  out  1
- result_ready  in  1

## Operation
- States:
  - LOAD, the reset state: weight_ready=1, image_ready=0.
    - Each accepted weight is written to index k = c*KERNEL_NB + kh*KERNEL_WIDTH + kw, with k incrementing from 0.
    - After index CHANNEL_NB*KERNEL_NB-1 is accepted: go to RUN, k←0.
    - reload is ignored in LOAD.
  - RUN: weight_ready=0; image_ready = !stall, where stall = result_valid && !result_ready.
    - A beat is accepted on image_valid && image_ready.
    - Channel counter c advances 0..CHANNEL_NB-1 and wraps.
  - DRAIN: entered from RUN on reload.
    - image_ready=0.
    - Channel counter and accumulator cleared, so a partial group is discarded.
    - A beat already accepted into S1 is dropped.
    - Next cycle: go to LOAD.
    - A completed result already in the result register is kept until it is accepted.
- Lane sum for accepted beat with channel c: S[s] = Σ_{kh,kw} w[c][kh][kw] * pix(kh, (s+kw) mod IMAGE_NB). Columns wrap around the row.
- Arithmetic is signed throughout. Products are sign-extended to ACC_WIDTH, which cannot overflow by construction.
- Pipeline:
  - S1 registers S[·], plus valid and last (last = c==CHANNEL_NB-1).
  - The accumulate stage adds S1 into acc, or loads S1 directly when c of that entry is 0.
  - On last: the result register ← acc+S1, result_valid←1, acc cleared.
- While stall holds, S1 and acc hold their values.
- result_valid falls on result_valid && result_ready unless a new result is loaded the same cycle.
- Weight valid/ready and result valid/ready follow standard rules: data is held stable while valid && !ready.

## Timing
- Reset values:
  - weight_ready=1, image_ready=0, result_valid=0, result=0.
  - state=LOAD, k=0, c=0, acc=0, S1 valid=0.
- Latency: the final beat of a group accepted at cycle t gives result_valid=1 at t+2.
- Throughput: one beat per cycle when unstalled.
- A result can be popped and a new result loaded in the same cycle.
- weight_ready rises 2 cycles after reload is sampled in RUN (RUN→DRAIN→LOAD).
- reload and an accepted image beat in the same cycle: the beat is dropped.
- Reset mid-operation returns every register to its reset value immediately. No partial result is emitted.

## Configuration
- ENGINE_RELU_EN defined: lanes that are negative are written to the result register as 0.
- ENGINE_RELU_EN undefined: raw signed accumulation is output.
- The macro affects only the result-register load path.

## Structure
- Shared package engine_pkg:
  - state enum {LOAD, RUN, DRAIN}
  - function acc_width(iw, ww, kn, cn), used to derive ACC_WIDTH
- Sub-module window_mac, one instance per lane: combinational signed dot product of KERNEL_NB weights × KERNEL_NB pixels, producing ACC_WIDTH bits.
- Top level holds the FSM, weight store, counters, S1, accumulator and result register.

## Test plan
All scenarios use IMAGE_NB=8, KERNEL_WIDTH=KERNEL_HEIGHT=3, CHANNEL_NB=2 unless noted.
- Reset: assert rst mid-stream → weight_ready=1, image_ready=0, result_valid=0, result=0; after release, 18 weights are required before image_ready=1.
- All ones: load 18 weights = 1, send 2 beats of all pixels = 1 → result_valid at t+2; every lane = 18.
- Wrap: w[0][0][2]=1, all other weights 0; row 0 pixel i = i in both beats → lane 0 = 2, lane 5 = 7, lane 6 = 0, lane 7 = 1.
- Signed / ReLU: all weights = -1, all pixels = 100 → every lane = -1800; with ENGINE_RELU_EN, every lane = 0.
- Backpressure: result_ready=0 for 10 cycles while streaming 3 groups → image_ready low after the first result; no result lost or reordered once ready=1.
- Mid-group reload: pulse reload after 1 beat → weight_ready=1 two cycles later; reload 18 all-ones weights, send 2 beats of ones → lanes = 18, no stale partial sum.
